// File: rtl/if_fetch_ctrl.sv
// Instruction fetch controller: sequences instruction SRAM reads and
// presents the fetched instruction's PC/valid to ID, with delay-slot branches.
module if_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'hbfc00000,
   parameter logic [31:0] EXC_PC   = 32'hbfc00380
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ID_allowin,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        exc_req,
   output logic        inst_sram_en,
   output logic [31:0] inst_sram_addr,
   output logic        ID_stall,
   output logic        ID_valid,
   output logic [31:0] ID_pc
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t      state;
   logic        br_pending;
   logic [31:0] br_target_q;
   logic [31:0] seq_pc;
   logic [31:0] next_pc;
   logic        br_take;

   assign seq_pc  = ID_pc + 32'd4;
   assign br_take = br_taken & ID_valid & ID_allowin;

   always_comb begin
      next_pc = seq_pc;
      if (exc_req)
         next_pc = EXC_PC;
      else if (br_pending)
         next_pc = br_target_q;
   end

   // SRAM request is a same-cycle function of state and inputs
   always_comb begin
      inst_sram_en   = 1'b0;
      inst_sram_addr = 32'd0;
      ID_stall       = 1'b0;
      if (!rst) begin
         ID_stall = ID_valid & ~ID_allowin;
         unique case (state)
            BOOT: begin
               inst_sram_en   = 1'b1;
               inst_sram_addr = RESET_PC;
            end
            RUN, HOLD: begin
               if (exc_req || ID_allowin) begin
                  inst_sram_en   = 1'b1;
                  inst_sram_addr = next_pc;
               end else begin
                  inst_sram_addr = seq_pc;
               end
            end
            default: begin
               inst_sram_en   = 1'b0;
               inst_sram_addr = 32'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= BOOT;
         ID_valid    <= 1'b0;
         ID_pc       <= 32'd0;
         br_pending  <= 1'b0;
         br_target_q <= 32'd0;
      end else begin
         unique case (state)
            BOOT: begin
               state    <= RUN;
               ID_pc    <= RESET_PC;
               ID_valid <= 1'b1;
            end
            RUN, HOLD: begin
               if (exc_req) begin
                  state      <= RUN;
                  ID_pc      <= EXC_PC;
                  ID_valid   <= 1'b1;
                  br_pending <= 1'b0;
               end else if (ID_allowin) begin
                  state    <= RUN;
                  ID_pc    <= next_pc;
                  ID_valid <= 1'b1;
                  // a branch in a delay slot re-arms the pending redirect
                  if (br_take) begin
                     br_target_q <= br_target;
                     br_pending  <= 1'b1;
                  end else begin
                     br_pending  <= 1'b0;
                  end
               end else begin
                  state <= HOLD;
               end
            end
            default: begin
               state <= BOOT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed-vector bench for if_fetch_ctrl; expected outputs are queued by
// the driver and checked by an independent monitor on the falling edge.
module tb_if_fetch_ctrl;

   typedef struct {
      logic        rst;
      logic        al;
      logic        bt;
      logic [31:0] tgt;
      logic        exc;
      logic        en;
      logic [31:0] addr;
      logic        achk;
      logic        stall;
      logic        valid;
      logic [31:0] pc;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        ID_allowin;
   logic        br_taken;
   logic [31:0] br_target;
   logic        exc_req;
   logic        inst_sram_en;
   logic [31:0] inst_sram_addr;
   logic        ID_stall;
   logic        ID_valid;
   logic [31:0] ID_pc;

   int checks = 0;
   int errors = 0;

   vec_t vecs[$];
   vec_t expq[$];

   if_fetch_ctrl dut (
      .clk(clk),
      .rst(rst),
      .ID_allowin(ID_allowin),
      .br_taken(br_taken),
      .br_target(br_target),
      .exc_req(exc_req),
      .inst_sram_en(inst_sram_en),
      .inst_sram_addr(inst_sram_addr),
      .ID_stall(ID_stall),
      .ID_valid(ID_valid),
      .ID_pc(ID_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int idx,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d: got %h want %h", name, idx, act, exp);
      end
   endtask

   task automatic v(input logic r, input logic al, input logic bt,
                    input logic [31:0] tgt, input logic exc,
                    input logic en, input logic [31:0] addr,
                    input logic achk, input logic stall,
                    input logic valid, input logic [31:0] pc);
      vec_t t;
      t.rst = r; t.al = al; t.bt = bt; t.tgt = tgt; t.exc = exc;
      t.en = en; t.addr = addr; t.achk = achk; t.stall = stall;
      t.valid = valid; t.pc = pc;
      vecs.push_back(t);
   endtask

   initial begin : monitor
      int n;
      vec_t e;
      n = 0;
      forever begin
         @(negedge clk);
         if (expq.size() != 0) begin
            e = expq.pop_front();
            chk("sram_en", n, {31'd0, inst_sram_en}, {31'd0, e.en});
            if (e.achk)
               chk("sram_addr", n, inst_sram_addr, e.addr);
            chk("id_stall", n, {31'd0, ID_stall}, {31'd0, e.stall});
            chk("id_valid", n, {31'd0, ID_valid}, {31'd0, e.valid});
            chk("id_pc", n, ID_pc, e.pc);
            n++;
         end
      end
   end

   initial begin : driver
      //  rst al bt tgt          exc  en addr         chk st va pc
      v(1, 1, 0, 32'h0,        0,  0, 32'h0,        1, 0, 0, 32'h0);
      v(0, 1, 0, 32'h0,        0,  1, 32'hbfc00000, 1, 0, 0, 32'h0);
      v(0, 1, 0, 32'h0,        0,  1, 32'hbfc00004, 1, 0, 1, 32'hbfc00000);
      v(0, 1, 0, 32'h0,        0,  1, 32'hbfc00008, 1, 0, 1, 32'hbfc00004);
      v(0, 0, 0, 32'h0,        0,  0, 32'h0,        0, 1, 1, 32'hbfc00008);
      v(0, 0, 0, 32'h0,        0,  0, 32'h0,        0, 1, 1, 32'hbfc00008);
      v(0, 0, 0, 32'h0,        0,  0, 32'h0,        0, 1, 1, 32'hbfc00008);
      v(0, 1, 0, 32'h0,        0,  1, 32'hbfc0000c, 1, 0, 1, 32'hbfc00008);
      v(0, 1, 0, 32'h0,        0,  1, 32'hbfc00010, 1, 0, 1, 32'hbfc0000c);
      v(0, 1, 1, 32'hbfc00100, 0,  1, 32'hbfc00014, 1, 0, 1, 32'hbfc00010);
      v(0, 1, 0, 32'h0,        0,  1, 32'hbfc00100, 1, 0, 1, 32'hbfc00014);
      v(0, 1, 0, 32'h0,        0,  1, 32'hbfc00104, 1, 0, 1, 32'hbfc00100);
      v(0, 1, 1, 32'hbfc00200, 0,  1, 32'hbfc00108, 1, 0, 1, 32'hbfc00104);
      v(0, 0, 0, 32'h0,        0,  0, 32'h0,        0, 1, 1, 32'hbfc00108);
      v(0, 0, 1, 32'hdeadbeef, 0,  0, 32'h0,        0, 1, 1, 32'hbfc00108);
      v(0, 1, 0, 32'h0,        0,  1, 32'hbfc00200, 1, 0, 1, 32'hbfc00108);
      v(0, 1, 0, 32'h0,        0,  1, 32'hbfc00204, 1, 0, 1, 32'hbfc00200);
      v(0, 1, 1, 32'hbfc00300, 0,  1, 32'hbfc00208, 1, 0, 1, 32'hbfc00204);
      v(0, 0, 0, 32'h0,        1,  1, 32'hbfc00380, 1, 1, 1, 32'hbfc00208);
      v(0, 1, 0, 32'h0,        0,  1, 32'hbfc00384, 1, 0, 1, 32'hbfc00380);
      v(0, 1, 1, 32'hbfc00500, 1,  1, 32'hbfc00380, 1, 0, 1, 32'hbfc00384);
      v(0, 1, 0, 32'h0,        0,  1, 32'hbfc00384, 1, 0, 1, 32'hbfc00380);
      v(0, 1, 1, 32'hfffffffc, 0,  1, 32'hbfc00388, 1, 0, 1, 32'hbfc00384);
      v(0, 1, 0, 32'h0,        0,  1, 32'hfffffffc, 1, 0, 1, 32'hbfc00388);
      v(0, 1, 0, 32'h0,        0,  1, 32'h00000000, 1, 0, 1, 32'hfffffffc);
      v(0, 1, 1, 32'h00000123, 0,  1, 32'h00000004, 1, 0, 1, 32'h00000000);
      v(0, 1, 0, 32'h0,        0,  1, 32'h00000123, 1, 0, 1, 32'h00000004);
      v(0, 1, 1, 32'h00000040, 0,  1, 32'h00000127, 1, 0, 1, 32'h00000123);
      v(0, 1, 1, 32'h00000080, 0,  1, 32'h00000040, 1, 0, 1, 32'h00000127);
      v(0, 1, 0, 32'h0,        0,  1, 32'h00000080, 1, 0, 1, 32'h00000040);
      v(0, 1, 1, 32'h00000300, 0,  1, 32'h00000084, 1, 0, 1, 32'h00000080);
      v(0, 0, 0, 32'h0,        0,  0, 32'h0,        0, 1, 1, 32'h00000084);
      v(1, 0, 0, 32'h0,        0,  0, 32'h0,        1, 0, 1, 32'h00000084);
      v(0, 1, 0, 32'h0,        0,  1, 32'hbfc00000, 1, 0, 0, 32'h0);
      v(0, 1, 0, 32'h0,        0,  1, 32'hbfc00004, 1, 0, 1, 32'hbfc00000);
      v(1, 1, 0, 32'h0,        0,  0, 32'h0,        1, 0, 1, 32'hbfc00004);
      v(0, 1, 1, 32'h00000500, 1,  1, 32'hbfc00000, 1, 0, 0, 32'h0);
      v(0, 1, 0, 32'h0,        0,  1, 32'hbfc00004, 1, 0, 1, 32'hbfc00000);

      rst = 1'b1; ID_allowin = 1'b1; br_taken = 1'b0;
      br_target = 32'd0; exc_req = 1'b0;
      repeat (2) @(posedge clk);
      foreach (vecs[i]) begin
         #1;
         rst        = vecs[i].rst;
         ID_allowin = vecs[i].al;
         br_taken   = vecs[i].bt;
         br_target  = vecs[i].tgt;
         exc_req    = vecs[i].exc;
         expq.push_back(vecs[i]);
         @(posedge clk);
      end
      repeat (2) @(negedge clk);
      chk("queue_drained", 0, expq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
